// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and constants for the fetch-address generator
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } pc_state_e;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_BR   = 2'd1;
    localparam logic [1:0] CAUSE_JMP  = 2'd2;
    localparam logic [1:0] CAUSE_TRAP = 2'd3;

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - combinational next-PC priority mux with target alignment check
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ILEN_BYTES = 4
) (
    input  logic [XLEN-1:0] pc,
    input  logic            stall,
    input  logic            imem_ready,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_pc,
    input  logic [XLEN-1:0] branch_offset,
    input  logic            jump_valid,
    input  logic [XLEN-1:0] jump_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] next_pc,
    output logic            take_redirect,
    output logic [1:0]      cause,
    output logic            misaligned
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(ILEN_BYTES - 1);

    logic [XLEN-1:0] br_target;

    assign br_target = branch_pc + branch_offset;

    // A misaligned winner is rejected outright; lower-priority sources never get a turn.
    always_comb begin
        next_pc       = pc + XLEN'(ILEN_BYTES);
        take_redirect = 1'b0;
        cause         = CAUSE_NONE;
        misaligned    = 1'b0;
        if (trap_valid) begin
            next_pc       = trap_vector & ~ALIGN_MASK;
            take_redirect = 1'b1;
            cause         = CAUSE_TRAP;
        end else if (branch_taken) begin
            if (|(br_target & ALIGN_MASK)) begin
                next_pc    = pc;
                misaligned = 1'b1;
            end else begin
                next_pc       = br_target;
                take_redirect = 1'b1;
                cause         = CAUSE_BR;
            end
        end else if (jump_valid) begin
            if (|(jump_target & ALIGN_MASK)) begin
                next_pc    = pc;
                misaligned = 1'b1;
            end else begin
                next_pc       = jump_target;
                take_redirect = 1'b1;
                cause         = CAUSE_JMP;
            end
        end else if (stall || !imem_ready) begin
            next_pc = pc;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch PC register, boot/run/fault FSM and registered redirect status
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0040_0000),
    parameter int              ILEN_BYTES   = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            imem_ready,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_pc,
    input  logic [XLEN-1:0] branch_offset,
    input  logic            jump_valid,
    input  logic [XLEN-1:0] jump_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic            flush,
    output logic [1:0]      redirect_cause,
    output logic            misaligned_fault
);

    pc_state_e       state_q;
    logic [XLEN-1:0] pc_q;
    logic            pc_valid_q;
    logic            flush_q;
    logic [1:0]      cause_q;
    logic            fault_q;

    logic [XLEN-1:0] pc_d;
    logic            redirect_d;
    logic [1:0]      cause_d;
    logic            misaligned_d;

    pc_next_sel #(
        .XLEN       (XLEN),
        .ILEN_BYTES (ILEN_BYTES)
    ) u_next_sel (
        .pc            (pc_q),
        .stall         (stall),
        .imem_ready    (imem_ready),
        .branch_taken  (branch_taken),
        .branch_pc     (branch_pc),
        .branch_offset (branch_offset),
        .jump_valid    (jump_valid),
        .jump_target   (jump_target),
        .trap_valid    (trap_valid),
        .trap_vector   (trap_vector),
        .next_pc       (pc_d),
        .take_redirect (redirect_d),
        .cause         (cause_d),
        .misaligned    (misaligned_d)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            pc_valid_q <= 1'b0;
            flush_q    <= 1'b0;
            cause_q    <= CAUSE_NONE;
            fault_q    <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            fault_q <= 1'b0;
            case (state_q)
                BOOT: begin
                    state_q    <= RUN;
                    pc_valid_q <= 1'b1;
                end
                RUN: begin
                    if (misaligned_d) begin
                        state_q    <= FAULT;
                        pc_valid_q <= 1'b0;
                        fault_q    <= 1'b1;
                    end else begin
                        pc_q <= pc_d;
                        if (redirect_d) begin
                            flush_q <= 1'b1;
                            cause_q <= cause_d;
                        end
                    end
                end
                FAULT: begin
                    // Only a trap recovers; the selector already puts trap first.
                    if (trap_valid) begin
                        state_q    <= RUN;
                        pc_valid_q <= 1'b1;
                        pc_q       <= pc_d;
                        flush_q    <= 1'b1;
                        cause_q    <= CAUSE_TRAP;
                    end
                end
                default: begin
                    state_q    <= BOOT;
                    pc_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign pc               = pc_q;
    assign pc_valid         = pc_valid_q;
    assign flush            = flush_q;
    assign redirect_cause   = cause_q;
    assign misaligned_fault = fault_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - scoreboard bench for pc_gen with directed and random stimulus
module tb_pc_gen;

    localparam logic [31:0] RV = 32'h0040_0000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall, imem_ready, branch_taken, jump_valid, trap_valid;
    logic [31:0] branch_pc, branch_offset, jump_target, trap_vector;
    logic [31:0] pc;
    logic        pc_valid, flush, misaligned_fault;
    logic [1:0]  redirect_cause;

    pc_gen dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .stall            (stall),
        .imem_ready       (imem_ready),
        .branch_taken     (branch_taken),
        .branch_pc        (branch_pc),
        .branch_offset    (branch_offset),
        .jump_valid       (jump_valid),
        .jump_target      (jump_target),
        .trap_valid       (trap_valid),
        .trap_vector      (trap_vector),
        .pc               (pc),
        .pc_valid         (pc_valid),
        .flush            (flush),
        .redirect_cause   (redirect_cause),
        .misaligned_fault (misaligned_fault)
    );

    always #5 clock = ~clock;

    typedef struct {
        int unsigned cyc;
        logic [31:0] pc;
        logic        valid;
        logic        flush;
        logic        fault;
        logic [1:0]  cause;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;

    // reference model state
    logic [31:0] m_pc;
    logic        m_boot, m_faulted;
    logic [1:0]  m_cause;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                chk("sb_missed", 32'(e.cyc), 32'(cyc));
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                chk("pc", pc, e.pc);
                chk("pc_valid", 32'(pc_valid), 32'(e.valid));
                chk("flush", 32'(flush), 32'(e.flush));
                chk("redirect_cause", 32'(redirect_cause), 32'(e.cause));
                chk("misaligned_fault", 32'(misaligned_fault), 32'(e.fault));
            end
        end
    end

    task automatic idle();
        stall = 0; imem_ready = 1; branch_taken = 0; jump_valid = 0; trap_valid = 0;
        branch_pc = 0; branch_offset = 0; jump_target = 0; trap_vector = 0;
    endtask

    task automatic model_reset();
        m_pc = RV; m_boot = 1; m_faulted = 0; m_cause = 0;
    endtask

    // Model one clock edge from the current inputs, queue the outcome, advance.
    task automatic step();
        exp_t        e;
        logic [31:0] t;
        logic [1:0]  c;
        logic        want;
        e.flush = 0; e.fault = 0;
        want = 0; t = 0; c = 0;
        if (m_boot) begin
            m_boot = 0;
        end else if (m_faulted) begin
            if (trap_valid) begin
                m_pc = trap_vector & ~32'd3; m_cause = 3; e.flush = 1; m_faulted = 0;
            end
        end else begin
            if (trap_valid) begin
                m_pc = trap_vector & ~32'd3; m_cause = 3; e.flush = 1;
            end else if (branch_taken) begin
                t = branch_pc + branch_offset; c = 1; want = 1;
            end else if (jump_valid) begin
                t = jump_target; c = 2; want = 1;
            end else if (!stall && imem_ready) begin
                m_pc = m_pc + 32'd4;
            end
            if (want) begin
                if (t % 4 != 0) begin
                    m_faulted = 1; e.fault = 1;
                end else begin
                    m_pc = t; m_cause = c; e.flush = 1;
                end
            end
        end
        e.pc = m_pc; e.valid = !m_faulted; e.cause = m_cause; e.cyc = cyc + 1;
        sb.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_pc"}, pc, RV);
        chk({tag, "_valid"}, 32'(pc_valid), 0);
        chk({tag, "_flush"}, 32'(flush), 0);
        chk({tag, "_cause"}, 32'(redirect_cause), 0);
        chk({tag, "_fault"}, 32'(misaligned_fault), 0);
    endtask

    initial begin
        int r;
        idle();
        reset_n = 0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_values("reset");
        model_reset();
        reset_n = 1;
        repeat (4) step();

        branch_taken = 1; branch_pc = 32'h0040_0010; branch_offset = 32'hFFFF_FFF0;
        step();
        idle(); step();

        stall = 1; jump_valid = 1; jump_target = 32'h0040_0100;
        step();
        jump_valid = 0;
        repeat (3) step();
        idle();

        imem_ready = 0;
        repeat (3) step();
        idle();

        jump_valid = 1; jump_target = 32'hFFFF_FFFC;
        step();
        idle(); repeat (3) step();

        jump_valid = 1; jump_target = 32'h0040_0102;
        step();
        idle(); stall = 1; branch_taken = 1; branch_pc = 32'h0040_0000; branch_offset = 32'h40;
        step();
        idle(); step();
        trap_valid = 1; trap_vector = 32'h0000_0080;
        step();
        idle(); step();

        trap_valid = 1; trap_vector = 32'h0000_0200;
        branch_taken = 1; branch_pc = 32'h0040_0000; branch_offset = 32'h8;
        step();
        idle(); step();

        trap_valid = 1; trap_vector = 32'h0000_0303;
        step();
        idle(); step();

        branch_taken = 1; branch_pc = 32'h0040_0000; branch_offset = 32'h6;
        jump_valid = 1; jump_target = 32'h0040_0400;
        step();
        idle(); step();

        @(negedge clock);
        #1;
        reset_n = 0;
        #1;
        check_reset_values("midreset");
        sb.delete();
        model_reset();
        @(posedge clock);
        #1;
        reset_n = 1;
        step();

        for (int i = 0; i < 500; i++) begin
            idle();
            stall      = ($urandom_range(0, 3) == 0);
            imem_ready = ($urandom_range(0, 4) != 0);
            r = int'($urandom_range(0, 19));
            branch_taken  = (r < 2);
            jump_valid    = (r >= 1 && r < 4);
            trap_valid    = (r == 19) || (m_faulted && $urandom_range(0, 5) == 0);
            branch_pc     = m_pc;
            branch_offset = 32'(($urandom_range(0, 511) - 256) * 4);
            if ($urandom_range(0, 3) == 0) branch_offset = branch_offset + 32'($urandom_range(1, 3));
            jump_target   = $urandom;
            if ($urandom_range(0, 2) != 0) jump_target = jump_target & ~32'd3;
            trap_vector   = $urandom;
            step();
        end
        idle();
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        chk("sb_drain", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
